// File: rtl/audio_step_sequencer_if.sv
// Control, pattern-write and channel-output bundle of the step sequencer.
// Carries no state and adds no latency.
// No backpressure: writes and start/stop strobes are accepted on the cycle they are presented.
interface audio_step_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  // host side: pattern write port and playback control
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [63:0]   wr_data_i;
  logic          start_i;
  logic          stop_i;
  logic          loop_i;
  logic [AW:0]   len_i;

  // sequencer side: status and mixer channel configuration
  logic          busy_o;
  logic [AW-1:0] step_o;
  logic          done_o;
  logic          ch0_en_o;
  logic [2:0]    ch0_gen_sel_o;
  logic [15:0]   ch0_freq_o;
  logic [7:0]    ch0_volume_o;
  logic          ch1_en_o;
  logic [2:0]    ch1_gen_sel_o;
  logic [15:0]   ch1_freq_o;
  logic [7:0]    ch1_volume_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i, len_i,
    input  busy_o, step_o, done_o,
           ch0_en_o, ch0_gen_sel_o, ch0_freq_o, ch0_volume_o,
           ch1_en_o, ch1_gen_sel_o, ch1_freq_o, ch1_volume_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i, len_i,
    output busy_o, step_o, done_o,
           ch0_en_o, ch0_gen_sel_o, ch0_freq_o, ch0_volume_o,
           ch1_en_o, ch1_gen_sel_o, ch1_freq_o, ch1_volume_o
  );
endinterface

// File: rtl/audio_step_sequencer.sv
// Two-channel step sequencer feeding the audio mixer's per-channel configuration from a pattern RAM.
// Step 0 appears on the edge that samples start; each step lasts max(dur,1) ticks plus an optional note-off gap.
// No backpressure: pattern writes land in any state, stop aborts on the next edge, start while busy is dropped.
module audio_step_sequencer #(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 12000,
  parameter int GAP_TICKS = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  audio_step_sequencer_if.slave bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int AW1    = AW + 1;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // duration counter must hold both an 8-bit step duration and the gap length
  localparam int CW     = (GAP_TICKS > 256) ? $clog2(GAP_TICKS) : 8;
  localparam int GAP_M1 = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   LEN_MAX  = AW1'(DEPTH);

  typedef struct packed {
    logic        en;
    logic [2:0]  gen_sel;
    logic [15:0] freq;
    logic [7:0]  volume;
  } ch_t;

  typedef struct packed {
    logic [7:0] dur;
    ch_t        ch1;
    ch_t        ch0;
  } entry_t;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  entry_t        ram [DEPTH];

  state_t        state;
  logic [PW-1:0] pre;
  logic [CW-1:0] dcnt;
  logic [7:0]    dur_m1;
  logic [AW-1:0] step;
  logic [AW-1:0] last_idx;
  logic          busy;
  logic          done;
  ch_t           ch0;
  ch_t           ch1;

  logic          tick;
  logic          play_last;
  logic          gap_last;
  logic          at_last;
  logic          do_advance;
  logic          do_finish;
  logic          do_load;
  logic [AW:0]   len_sel;
  logic [AW-1:0] len_last;
  logic [AW-1:0] load_idx;
  entry_t        ld;
  logic [7:0]    ld_dur_m1;

  // pattern RAM: host writes land in any state; the array is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (bus.wr_en_i) begin
      ram[bus.wr_addr_i] <= entry_t'(bus.wr_data_i);
    end
  end

  // tick/end-of-step detection, next-step selection and length clamping
  always_comb begin
    tick       = (pre == PRE_LAST);
    play_last  = tick && (dcnt == CW'(dur_m1));
    gap_last   = tick && (dcnt == CW'(GAP_M1));
    at_last    = (step == last_idx);
    // with no gap the step advances straight out of PLAY
    do_advance = ((state == PLAY) && play_last && (GAP_TICKS == 0)) ||
                 ((state == GAP) && gap_last);
    do_finish  = do_advance && at_last && !bus.loop_i;
    do_load    = ((state == IDLE) && bus.start_i) || (do_advance && !do_finish);

    len_sel = bus.len_i;
    if ((bus.len_i == '0) || (bus.len_i > LEN_MAX)) begin
      len_sel = LEN_MAX;
    end
    len_last = AW'(len_sel - AW1'(1));

    // IDLE start and loop wrap both load step 0
    load_idx = '0;
    if ((state != IDLE) && !at_last) begin
      load_idx = step + AW'(1);
    end
    ld        = ram[load_idx];
    ld_dur_m1 = (ld.dur == 8'd0) ? 8'd0 : (ld.dur - 8'd1);
  end

  // playback FSM with registered status and channel outputs
  always_ff @(posedge clk_i) begin
    done <= 1'b0;
    if (rst_i) begin
      state    <= IDLE;
      pre      <= '0;
      dcnt     <= '0;
      dur_m1   <= '0;
      step     <= '0;
      last_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ch0      <= '0;
      ch1      <= '0;
    end else if (bus.stop_i) begin
      // abort: silence the mixer, keep the step index for inspection
      state <= IDLE;
      pre   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      ch0   <= '0;
      ch1   <= '0;
    end else if (do_load) begin
      state  <= PLAY;
      pre    <= '0;
      dcnt   <= '0;
      dur_m1 <= ld_dur_m1;
      step   <= load_idx;
      busy   <= 1'b1;
      ch0    <= ld.ch0;
      ch1    <= ld.ch1;
      // the pattern length is latched only when playback starts
      if (state == IDLE) begin
        last_idx <= len_last;
      end
    end else if (do_finish) begin
      state <= IDLE;
      pre   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b1;
      ch0   <= '0;
      ch1   <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (tick) begin
            pre <= '0;
            if (play_last) begin
              // note-off gap: mute both channels, other fields keep their values
              state  <= GAP;
              dcnt   <= '0;
              ch0.en <= 1'b0;
              ch1.en <= 1'b0;
            end else begin
              dcnt <= dcnt + CW'(1);
            end
          end else begin
            pre <= pre + PW'(1);
          end
        end
        GAP: begin
          if (tick) begin
            pre  <= '0;
            dcnt <= dcnt + CW'(1);
          end else begin
            pre <= pre + PW'(1);
          end
        end
        default: begin
          pre  <= '0;
          dcnt <= '0;
        end
      endcase
    end
  end

  assign bus.busy_o        = busy;
  assign bus.step_o        = step;
  assign bus.done_o        = done;
  assign bus.ch0_en_o      = ch0.en;
  assign bus.ch0_gen_sel_o = ch0.gen_sel;
  assign bus.ch0_freq_o    = ch0.freq;
  assign bus.ch0_volume_o  = ch0.volume;
  assign bus.ch1_en_o      = ch1.en;
  assign bus.ch1_gen_sel_o = ch1.gen_sel;
  assign bus.ch1_freq_o    = ch1.freq;
  assign bus.ch1_volume_o  = ch1.volume;

endmodule

// File: tb/tb_audio_step_sequencer.sv
// Directed bench for audio_step_sequencer: a gap build (GAP_TICKS=1) and a no-gap build (GAP_TICKS=0).
// Segment table drives start/stop/loop and checks every output cycle; corner cases are hand sequences.
// Inputs change after the falling edge, outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_audio_step_sequencer;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  audio_step_sequencer_if #(.DEPTH(DEPTH)) bus  ();
  audio_step_sequencer_if #(.DEPTH(DEPTH)) bus0 ();

  audio_step_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .GAP_TICKS(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  audio_step_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .GAP_TICKS(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  typedef struct packed {
    logic        busy;
    logic [1:0]  step;
    logic        done;
    logic        en0;
    logic        en1;
    logic [15:0] freq0;
    logic [7:0]  vol0;
    logic [15:0] freq1;
  } obs_t;

  typedef struct {
    logic start;
    logic stop;
    logic loop;
    int   n;
    obs_t exp;
  } seg_t;

  localparam int NSEG = 19;
  seg_t tbl [NSEG];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic obs_t mk(input logic b, input logic [1:0] s, input logic d, input logic e0,
                              input logic e1, input logic [15:0] f0, input logic [7:0] v0,
                              input logic [15:0] f1);
    obs_t o;
    o = '{busy: b, step: s, done: d, en0: e0, en1: e1, freq0: f0, vol0: v0, freq1: f1};
    return o;
  endfunction

  function automatic seg_t sg(input logic st, input logic sp, input logic lp, input int n, input obs_t e);
    seg_t r;
    r.start = st; r.stop = sp; r.loop = lp; r.n = n; r.exp = e;
    return r;
  endfunction

  // {dur, ch1, ch0}, each channel {en, gen_sel, freq, volume}
  function automatic logic [63:0] ent(input logic [7:0] dur,
                                      input logic e0, input logic [2:0] g0, input logic [15:0] f0, input logic [7:0] v0,
                                      input logic e1, input logic [2:0] g1, input logic [15:0] f1, input logic [7:0] v1);
    return {dur, e1, g1, f1, v1, e0, g0, f0, v0};
  endfunction

  function automatic obs_t cur();
    return mk(bus.busy_o, bus.step_o, bus.done_o, bus.ch0_en_o, bus.ch1_en_o,
              bus.ch0_freq_o, bus.ch0_volume_o, bus.ch1_freq_o);
  endfunction

  function automatic obs_t cur0();
    return mk(bus0.busy_o, bus0.step_o, bus0.done_o, bus0.ch0_en_o, bus0.ch1_en_o,
              bus0.ch0_freq_o, bus0.ch0_volume_o, bus0.ch1_freq_o);
  endfunction

  function automatic logic [59:0] all_out(input int which);
    if (which == 0)
      return {bus.busy_o, bus.step_o, bus.done_o, bus.ch0_en_o, bus.ch0_gen_sel_o, bus.ch0_freq_o,
              bus.ch0_volume_o, bus.ch1_en_o, bus.ch1_gen_sel_o, bus.ch1_freq_o, bus.ch1_volume_o};
    return {bus0.busy_o, bus0.step_o, bus0.done_o, bus0.ch0_en_o, bus0.ch0_gen_sel_o, bus0.ch0_freq_o,
            bus0.ch0_volume_o, bus0.ch1_en_o, bus0.ch1_gen_sel_o, bus0.ch1_freq_o, bus0.ch1_volume_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [63:0] d);
    bus.wr_en_i  = 1'b1; bus.wr_addr_i  = 2'(a); bus.wr_data_i  = d;
    bus0.wr_en_i = 1'b1; bus0.wr_addr_i = 2'(a); bus0.wr_data_i = d;
    tick_clk();
    bus.wr_en_i  = 1'b0;
    bus0.wr_en_i = 1'b0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.loop_i  = tbl[i].loop;
      bus.start_i = tbl[i].start;
      bus.stop_i  = tbl[i].stop;
      for (int c = 0; c < tbl[i].n; c++) begin
        tick_clk();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        check($sformatf("seg%0d.cyc%0d", i, c), 64'(cur()), 64'(tbl[i].exp));
      end
    end
  endtask

  logic [63:0] S0, S1;
  obs_t E0, G0, E1, G1, D1, I1, I0;

  initial begin
    S0 = ent(8'd2, 1'b1, 3'd1, 16'h0100, 8'h80, 1'b0, 3'd2, 16'h0055, 8'h11);
    S1 = ent(8'd1, 1'b0, 3'd3, 16'h0033, 8'h22, 1'b1, 3'd4, 16'h0200, 8'h40);
    E0 = mk(1, 2'd0, 0, 1, 0, 16'h0100, 8'h80, 16'h0055);
    G0 = mk(1, 2'd0, 0, 0, 0, 16'h0100, 8'h80, 16'h0055);
    E1 = mk(1, 2'd1, 0, 0, 1, 16'h0033, 8'h22, 16'h0200);
    G1 = mk(1, 2'd1, 0, 0, 0, 16'h0033, 8'h22, 16'h0200);
    D1 = mk(0, 2'd1, 1, 0, 0, 16'h0, 8'h0, 16'h0);
    I1 = mk(0, 2'd1, 0, 0, 0, 16'h0, 8'h0, 16'h0);
    I0 = mk(0, 2'd0, 0, 0, 0, 16'h0, 8'h0, 16'h0);

    // one-shot, two steps
    tbl[0]  = sg(1, 0, 0, 8, E0);
    tbl[1]  = sg(0, 0, 0, 4, G0);
    tbl[2]  = sg(0, 0, 0, 4, E1);
    tbl[3]  = sg(0, 0, 0, 4, G1);
    tbl[4]  = sg(0, 0, 0, 1, D1);
    tbl[5]  = sg(0, 0, 0, 2, I1);
    // looped, loop dropped during the second pass of step 1
    tbl[6]  = sg(1, 0, 1, 8, E0);
    tbl[7]  = sg(0, 0, 1, 4, G0);
    tbl[8]  = sg(0, 0, 1, 4, E1);
    tbl[9]  = sg(0, 0, 1, 4, G1);
    tbl[10] = sg(0, 0, 1, 8, E0);
    tbl[11] = sg(0, 0, 1, 4, G0);
    tbl[12] = sg(0, 0, 0, 4, E1);
    tbl[13] = sg(0, 0, 0, 4, G1);
    tbl[14] = sg(0, 0, 0, 1, D1);
    tbl[15] = sg(0, 0, 0, 2, I1);
    // stop mid step 0, then start+stop together from IDLE
    tbl[16] = sg(1, 0, 0, 3, E0);
    tbl[17] = sg(0, 1, 0, 2, I0);
    tbl[18] = sg(1, 1, 0, 3, I0);

    bus.wr_en_i = 0;  bus.wr_addr_i = '0;  bus.wr_data_i = '0;
    bus.start_i = 0;  bus.stop_i = 0;  bus.loop_i = 0;  bus.len_i = 3'd2;
    bus0.wr_en_i = 0; bus0.wr_addr_i = '0; bus0.wr_data_i = '0;
    bus0.start_i = 0; bus0.stop_i = 0; bus0.loop_i = 0; bus0.len_i = 3'd2;

    // reset for 3 cycles with start held high: everything stays at zero
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus0.start_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick_clk();
      check($sformatf("reset.gap.cyc%0d", c), 64'(all_out(0)), 64'd0);
      check($sformatf("reset.nogap.cyc%0d", c), 64'(all_out(1)), 64'd0);
    end
    bus.start_i = 1'b0;
    bus0.start_i = 1'b0;
    rst = 1'b0;
    tick_clk();
    check("idle.after_reset", 64'(all_out(0)), 64'd0);

    wr(0, S0);
    wr(1, S1);

    run_range(0, NSEG - 1);

    // reset mid-play: IDLE next edge, no done pulse
    bus.start_i = 1'b1;
    tick_clk();
    bus.start_i = 1'b0;
    tick_clk();
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    check("rst_midplay", 64'(cur()), 64'(I0));
    tick_clk();
    check("rst_midplay.next", 64'(cur()), 64'(I0));

    // pattern rewrites while step 0 is playing
    bus.start_i = 1'b1;
    tick_clk();
    bus.start_i = 1'b0;
    wr(1, ent(8'd1, 1'b0, 3'd3, 16'h0033, 8'h22, 1'b1, 3'd4, 16'h0777, 8'h40));
    wr(0, ent(8'd2, 1'b1, 3'd1, 16'h0999, 8'h80, 1'b0, 3'd2, 16'h0055, 8'h11));
    check("rewr0.obs3", 64'(cur()), 64'(E0));
    for (int c = 0; c < 5; c++) tick_clk();
    check("rewr0.obs8", 64'(cur()), 64'(E0));
    for (int c = 0; c < 5; c++) tick_clk();
    check("rewr1.step1", 64'(cur()), 64'(mk(1, 2'd1, 0, 0, 1, 16'h0033, 8'h22, 16'h0777)));
    begin
      int seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
        tick_clk();
        if (bus.done_o) seen = 1;
      end
      check("rewr.done_seen", 64'(seen), 64'd1);
    end
    wr(0, S0);
    wr(1, S1);

    // dur=0 plays as one tick
    wr(0, ent(8'd0, 1'b1, 3'd1, 16'h0100, 8'h80, 1'b0, 3'd0, 16'h0000, 8'h00));
    bus.len_i = 3'd1;
    bus.start_i = 1'b1;
    begin
      int en_cnt = 0;
      int seen = 0;
      for (int c = 0; c < 30 && seen == 0; c++) begin
        tick_clk();
        bus.start_i = 1'b0;
        if (bus.ch0_en_o) en_cnt++;
        if (bus.done_o) seen = 1;
      end
      check("dur0.en_cycles", 64'(en_cnt), 64'd4);
      check("dur0.done_seen", 64'(seen), 64'd1);
    end

    // len=0 plays all four steps
    for (int s = 0; s < 4; s++) begin
      wr(s, ent(8'd1, 1'b1, 3'd0, 16'(16'h1000 + s), 8'h10, 1'b0, 3'd0, 16'h0000, 8'h00));
    end
    bus.len_i = 3'd0;
    bus.start_i = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick_clk();
        bus.start_i = 1'b0;
        check($sformatf("len0.s%0d.c%0d", s, c), 64'({bus.step_o, bus.ch0_en_o, bus.ch0_freq_o}),
              64'({2'(s), 1'b1, 16'(16'h1000 + s)}));
      end
      for (int c = 0; c < 4; c++) tick_clk();
      check($sformatf("len0.gap%0d", s), 64'({bus.step_o, bus.ch0_en_o, bus.busy_o}), 64'({2'(s), 1'b0, 1'b1}));
    end
    tick_clk();
    check("len0.done", 64'({bus.busy_o, bus.done_o, bus.step_o}), 64'({1'b0, 1'b1, 2'd3}));

    // no-gap build: step 1 follows the last tick of step 0 directly
    wr(0, S0);
    wr(1, S1);
    bus0.len_i = 3'd2;
    bus0.start_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick_clk();
      bus0.start_i = 1'b0;
      check($sformatf("nogap.cyc%0d", c + 1), 64'(cur0()), (c < 8) ? 64'(E0) : 64'(E1));
    end
    tick_clk();
    check("nogap.done", 64'(cur0()), 64'(D1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_step_sequencer.md
Name: audio_step_sequencer

Overview:
Two-channel step sequencer that drives the per-channel configuration inputs (enable, generator select, frequency, volume) of the two-channel audio mixer. It plays a programmable pattern of up to DEPTH steps, each with its own duration in tempo ticks, an optional note-off gap between steps, and one-shot or looped playback. The pattern RAM is written by the host or test controller.

Parameters:
DEPTH, 16, number of pattern steps; must be a power of two, at least 2
TICK_DIV, 12000, clk_i cycles per tempo tick; at least 1
GAP_TICKS, 1, ticks of forced note-off after each step; 0 means no gap

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
wr_en_i  in  1  pattern write strobe
wr_addr_i  in  $clog2(DEPTH)  pattern step address
wr_data_i  in  64  {dur[63:56], ch1[55:28], ch0[27:0]}; each chX = {en[27], gen_sel[26:24], freq[23:8], volume[7:0]}
start_i  in  1  start playback from step 0 (pulse)
stop_i  in  1  abort playback (pulse)
loop_i  in  1  restart at step 0 after last step instead of finishing
len_i  in  $clog2(DEPTH)+1  pattern length in steps; 0 or >DEPTH is treated as DEPTH
busy_o  out  1  high while playing (PLAY or GAP)
step_o  out  $clog2(DEPTH)  index of current step
done_o  out  1  one-cycle pulse when non-looped playback completes
ch0_en_o  out  1  channel 0 enable
ch0_gen_sel_o  out  3  channel 0 generator select
ch0_freq_o  out  16  channel 0 frequency word
ch0_volume_o  out  8  channel 0 volume
ch1_en_o  out  1  channel 1 enable
ch1_gen_sel_o  out  3  channel 1 generator select
ch1_freq_o  out  16  channel 1 frequency word
ch1_volume_o  out  8  channel 1 volume

Behaviour:
- Reset: state IDLE. All ch outputs, busy_o, step_o and done_o are 0. Prescaler and duration counter are 0. Pattern RAM is not cleared. Reset mid-play goes to IDLE on the next edge with no done_o pulse.
- Pattern RAM: DEPTH x 64 register array, written on wr_en_i in any state. A write to a step takes effect the next time that step is loaded. Outputs already loaded are unaffected.
- States: IDLE, PLAY, GAP.
- IDLE -> PLAY: start_i=1 at edge N.
  - len_i is captured.
  - At N+1: step_o=0, busy_o=1, ch outputs = entry 0.
  - Prescaler and duration counter restart.
- Tick: prescaler counts 0..TICK_DIV-1 and strobes on the terminal count. It restarts at every step load and every GAP entry.
- PLAY: holds the step fields for max(dur,1) ticks, so dur=0 behaves as 1. Enables are high for exactly max(dur,1)*TICK_DIV cycles.
- End of PLAY duration:
  - If GAP_TICKS>0: go to GAP. ch0_en_o and ch1_en_o are forced to 0 for GAP_TICKS*TICK_DIV cycles. gen_sel, freq and volume hold.
  - If GAP_TICKS=0: the next step loads on the cycle after the last tick.
- Step advance, evaluated after GAP (or directly after PLAY when GAP_TICKS=0):
  - If step_o < len-1: load step_o+1.
  - Else, if loop_i=1 (sampled at that cycle): load step 0.
  - Else: go to IDLE. All ch outputs are zeroed, busy_o=0, done_o=1 for one cycle, step_o holds its last value.
- stop_i:
  - Has priority over all events except reset. Next edge: IDLE, all ch outputs 0, busy_o=0, no done_o.
  - stop_i and start_i in the same cycle: stop wins and the sequencer stays in IDLE.
- start_i while busy is ignored. len_i changes while busy are ignored.
- A channel disabled in its entry (en=0) outputs en=0 during PLAY. Its other fields are still driven from the entry.
- step_o wraps only through the loop rule. It never exceeds len-1.

Test Plan:
- Reset/idle (DEPTH=4, TICK_DIV=4, GAP_TICKS=1): assert rst_i for 3 cycles -> every output 0. start_i with rst_i=1 -> busy_o stays 0.
- One-shot, 2 steps (step0 dur=2, ch0 en=1/freq=0x0100/vol=0x80; step1 dur=1, ch1 en=1/freq=0x0200), len_i=2, loop_i=0, start at edge N -> expected sequence:
  - N+1 to N+8: ch0_en_o=1.
  - N+9 to N+12: gap, both enables 0.
  - N+13 to N+16: ch1_en_o=1.
  - N+17 to N+20: gap.
  - Then done_o pulses once, busy_o=0 and all outputs 0.
- Loop: same pattern with loop_i=1 -> step_o sequence 0,1,0,1,... with no done_o. Drop loop_i during step 1 -> finishes after that step with one done_o pulse.
- Stop/priority: stop_i in the middle of step 0 -> next cycle busy_o=0, outputs 0, no done_o. start_i and stop_i in the same cycle from IDLE -> stays IDLE.
- Edge fields: dur=0 -> enables high for 4 cycles. len_i=0 -> plays all 4 steps. Rewrite step 1 during step 0 -> step 1 plays the new data. Rewrite step 0 during step 0 -> current outputs unchanged.
- GAP_TICKS=0 build: step-to-step transition has no en=0 cycle. step1 fields appear on the cycle after the last tick of step0.
